bus_seg7_display: RTL and testbench

- Memory-mapped seven-segment and LED peripheral on the 6502 data bus, downstream of the CPU.
- Decodes an 8-byte I/O window and latches CPU writes into display registers.
- Returns register contents on reads, using the same synchronous-read timing as rom_or_ram.
- Autonomously scans an 8-digit multiplexed hex display and drives 4 LEDs.

---
 rtl/bus_seg7_pkg.sv | 23 ++
 rtl/bus_seg7_display_if.sv | 25 ++
 rtl/hex_to_seg7.sv | 13 +
 rtl/bus_seg7_display.sv | 130 +++++++++++++
 tb/tb_bus_seg7_display.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_seg7_pkg.sv
// Shared constants for the bus-mapped seven-segment display peripheral.
//   - Register offsets within the 8-byte I/O window (addr[2:0]).
//   - CTRL register bit assignment.
//   - Hex digit to active-high gfedcba segment table.
package bus_seg7_pkg;

    localparam logic [2:0] OFF_DIG0  = 3'd0;
    localparam logic [2:0] OFF_DIG1  = 3'd1;
    localparam logic [2:0] OFF_DIG2  = 3'd2;
    localparam logic [2:0] OFF_DIG3  = 3'd3;
    localparam logic [2:0] OFF_DP    = 3'd4;
    localparam logic [2:0] OFF_BLANK = 3'd5;
    localparam logic [2:0] OFF_LED   = 3'd6;
    localparam logic [2:0] OFF_CTRL  = 3'd7;

    localparam int unsigned CTRL_EN_BIT = 0;

    localparam logic [6:0] HEX7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/bus_seg7_display_if.sv
// CPU-side bus of the seven-segment peripheral.
//   cpu_strobe : one-clk pulse marking a CPU bus cycle
//   addr       : CPU address bus
//   wdata      : CPU write data
//   we         : CPU write enable
//   rdata      : registered read data back to the CPU
//   rd_sel     : rdata belongs to this peripheral for the current CPU cycle
interface bus_seg7_display_if;
    logic        cpu_strobe;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        rd_sel;

    modport master (
        output cpu_strobe, addr, wdata, we,
        input  rdata, rd_sel
    );

    modport slave (
        input  cpu_strobe, addr, wdata, we,
        output rdata, rd_sel
    );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to seven-segment pattern.
//   nibble : 4-bit hex value
//   seg    : active-high segments {g,f,e,d,c,b,a}
module hex_to_seg7
    import bus_seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX7_TABLE[nibble];

endmodule

// File: rtl/bus_seg7_display.sv
// Memory-mapped 8-digit multiplexed hex display and LED peripheral.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : CPU bus (slave side), writes latch registers, reads are registered
//   seg_sel    : digit enables, active-low, bit n = digit n
//   seg_data   : segments {dp,g,f,e,d,c,b,a}, inverted when SEG_ACTIVE_LOW
//   led        : LED outputs, active-high
module bus_seg7_display
    import bus_seg7_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = 16'h6000,
    parameter int unsigned SCAN_BITS      = 16,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bus_seg7_display_if.slave    bus,
    output logic [7:0]           seg_sel,
    output logic [7:0]           seg_data,
    output logic [3:0]           led
);

    // Segment value with every segment dark, for either board polarity.
    localparam logic [7:0] SEG_OFF = {8{SEG_ACTIVE_LOW}};

    logic [3:0][7:0]      dig_q;
    logic [7:0]           dp_q;
    logic [7:0]           blank_q;
    logic [3:0]           led_reg_q;
    logic                 en_q;
    logic [7:0]           rdata_q;
    logic                 rd_sel_q;
    logic [SCAN_BITS-1:0] prescaler_q;
    logic [2:0]           idx_q;
    logic [7:0]           seg_sel_q;
    logic [7:0]           seg_data_q;
    logic [3:0]           led_q;

    logic       hit;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] reg_rd;
    logic       tick;
    logic [3:0] nibble;
    logic [6:0] seg7;
    logic       digit_on;

    assign hit   = bus.addr[15:3] == BASE_ADDR[15:3];
    assign wr_en = bus.cpu_strobe & bus.we & hit;
    assign rd_en = bus.cpu_strobe & ~bus.we;

    always_comb begin
        reg_rd = 8'h00;
        case (bus.addr[2:0])
            OFF_DIG0, OFF_DIG1, OFF_DIG2, OFF_DIG3: reg_rd = dig_q[bus.addr[1:0]];
            OFF_DP:    reg_rd = dp_q;
            OFF_BLANK: reg_rd = blank_q;
            OFF_LED:   reg_rd = {4'h0, led_reg_q};
            OFF_CTRL:  reg_rd = {7'h00, en_q};
            default:   reg_rd = 8'h00;
        endcase
    end

    // Register file and CPU read path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q     <= '0;
            dp_q      <= 8'h00;
            blank_q   <= 8'h00;
            led_reg_q <= 4'h0;
            en_q      <= 1'b0;
            rdata_q   <= 8'h00;
            rd_sel_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                case (bus.addr[2:0])
                    OFF_DIG0, OFF_DIG1, OFF_DIG2, OFF_DIG3: dig_q[bus.addr[1:0]] <= bus.wdata;
                    OFF_DP:    dp_q      <= bus.wdata;
                    OFF_BLANK: blank_q   <= bus.wdata;
                    OFF_LED:   led_reg_q <= bus.wdata[3:0];
                    OFF_CTRL:  en_q      <= bus.wdata[CTRL_EN_BIT];
                    default:   ;
                endcase
            end
            if (rd_en) begin
                rd_sel_q <= hit;
                if (hit) begin
                    rdata_q <= reg_rd;
                end
            end else if (bus.cpu_strobe) begin
                rd_sel_q <= 1'b0;
            end
        end
    end

    // Scan: index advances on tick; the edge that sees tick blanks all digits
    // for one cycle so the outgoing digit does not ghost onto the next one.
    assign tick     = &prescaler_q;
    assign nibble   = idx_q[0] ? dig_q[idx_q[2:1]][7:4] : dig_q[idx_q[2:1]][3:0];
    assign digit_on = en_q & ~blank_q[idx_q] & ~tick;

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (seg7)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            idx_q       <= 3'd0;
            seg_sel_q   <= 8'hFF;
            seg_data_q  <= SEG_OFF;
            led_q       <= 4'h0;
        end else begin
            prescaler_q <= prescaler_q + 1'b1;
            if (tick) begin
                idx_q <= idx_q + 3'd1;
            end
            seg_sel_q  <= digit_on ? ~(8'b1 << idx_q) : 8'hFF;
            seg_data_q <= digit_on ? ({dp_q[idx_q], seg7} ^ SEG_OFF) : SEG_OFF;
            led_q      <= led_reg_q;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rd_sel = rd_sel_q;
    assign seg_sel    = seg_sel_q;
    assign seg_data   = seg_data_q;
    assign led        = led_q;

endmodule

// File: tb/tb_bus_seg7_display.sv
// Bench for bus_seg7_display: read responses go through a scoreboard queue
// popped by a bus monitor; display outputs are checked against a timeline
// anchored on the first observed digit-0 slot.
module tb_bus_seg7_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] seg_sel;
    logic [7:0] seg_data;
    logic [3:0] led;

    bus_seg7_display_if bus_if ();

    bus_seg7_display #(
        .BASE_ADDR      (16'h6000),
        .SCAN_BITS      (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .seg_sel  (seg_sel),
        .seg_data (seg_data),
        .led      (led)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic       sel;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    rd_q [$];
    string      rd_name_q [$];
    logic [7:0] last_rdata = 8'h00;
    int         t0 = 0;

    // Active-low segment patterns for the digits written in the main test:
    // nibbles 2,1,4,3,6,5,8,7 with DP on digits 0 and 7.
    logic [7:0] exp_seg [8] = '{8'h24, 8'hF9, 8'h99, 8'hB0, 8'h82, 8'h92, 8'h80, 8'h78};

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Read monitor: every CPU read cycle must have a queued expectation.
    rd_exp_t mon_e;
    string   mon_nm;
    always begin
        @(posedge clk);
        if (rst_n && bus_if.cpu_strobe && !bus_if.we) begin
            #1;
            if (rd_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rd_unexpected: got read at %04h expected none", bus_if.addr);
            end else begin
                mon_e  = rd_q.pop_front();
                mon_nm = rd_name_q.pop_front();
                check8({mon_nm, ".rd_sel"}, {7'h00, bus_if.rd_sel}, {7'h00, mon_e.sel});
                check8({mon_nm, ".rdata"}, bus_if.rdata, mon_e.data);
            end
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic strobe = 1'b1);
        @(negedge clk);
        bus_if.addr       = a;
        bus_if.wdata      = d;
        bus_if.we         = 1'b1;
        bus_if.cpu_strobe = strobe;
        @(negedge clk);
        bus_if.cpu_strobe = 1'b0;
        bus_if.we         = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic hit, input logic [7:0] exp,
                            input string nm);
        rd_exp_t e;
        if (hit) last_rdata = exp;
        e.sel  = hit;
        e.data = last_rdata;
        rd_q.push_back(e);
        rd_name_q.push_back(nm);
        @(negedge clk);
        bus_if.addr       = a;
        bus_if.we         = 1'b0;
        bus_if.cpu_strobe = 1'b1;
        @(negedge clk);
        bus_if.cpu_strobe = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Expected display at the current cycle: 16-cycle slots, last cycle dark.
    task automatic check_scan(input string nm, input logic [7:0] blank, input logic en);
        int         p;
        int         d;
        logic [7:0] es;
        logic [7:0] ed;
        p = (cyc - t0) % 128;
        d = p / 16;
        if ((p % 16) == 15 || !en || blank[d]) begin
            es = 8'hFF;
            ed = 8'hFF;
        end else begin
            es = ~(8'h01 << d);
            ed = exp_seg[d];
        end
        check8($sformatf("%s.d%0d.seg_sel", nm, d), seg_sel, es);
        check8($sformatf("%s.d%0d.seg_data", nm, d), seg_data, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        logic [7:0] prev;
        bit         found;
        logic [7:0] rd_vals [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h81, 8'h00, 8'h00, 8'h01};

        bus_if.cpu_strobe = 1'b0;
        bus_if.we         = 1'b0;
        bus_if.addr       = 16'h0000;
        bus_if.wdata      = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-operation.
        bus_write(16'h6006, 8'hFF);
        bus_write(16'h6007, 8'h01);
        bus_read(16'h6006, 1'b1, 8'h0F, "pre_rst_led");
        repeat (3) @(negedge clk);
        check8("pre_rst.led", {4'h0, led}, 8'h0F);
        #3 rst_n = 1'b0;
        #1;
        check8("rst.seg_sel", seg_sel, 8'hFF);
        check8("rst.seg_data", seg_data, 8'hFF);
        check8("rst.led", {4'h0, led}, 8'h00);
        check8("rst.rd_sel", {7'h00, bus_if.rd_sel}, 8'h00);
        check8("rst.rdata", bus_if.rdata, 8'h00);
        last_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_read(16'h6000 + 16'(i), 1'b1, 8'h00, $sformatf("rst_rd%0d", i));
        end

        // Register write / readback.
        bus_write(16'h6000, 8'h12);
        bus_write(16'h6001, 8'h34);
        bus_write(16'h6002, 8'h56);
        bus_write(16'h6003, 8'h78);
        bus_write(16'h6004, 8'h81);
        bus_write(16'h6007, 8'h01);
        for (int i = 0; i < 8; i++) begin
            bus_read(16'h6000 + 16'(i), 1'b1, rd_vals[i], $sformatf("rd%0d", i));
        end

        // Anchor the timeline on the dark cycle that precedes digit 0.
        found = 1'b0;
        prev  = seg_sel;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (prev == 8'hFF && seg_sel == 8'hFE) begin
                found = 1'b1;
                t0    = cyc;
            end
            prev = seg_sel;
        end
        n_vec++;
        if (!found) begin
            n_bad++;
            $display("FAIL scan_align: got no FF->FE step expected one within 400 cycles");
        end

        // Full scan including the 7 -> 0 wrap.
        for (int k = 0; k < 9; k++) begin
            wait_cyc(t0 + 16 * k + 7);
            check_scan("scan_mid", 8'h00, 1'b1);
            wait_cyc(t0 + 16 * k + 15);
            check_scan("scan_dead", 8'h00, 1'b1);
        end

        // Blank digit 2.
        bus_write(16'h6005, 8'h04);
        base = t0 + 128 * ((cyc - t0) / 128 + 1);
        for (int k = 1; k < 4; k++) begin
            wait_cyc(base + 16 * k + 7);
            check_scan("blank", 8'h04, 1'b1);
        end
        bus_write(16'h6005, 8'h00);

        // Display disabled: dark, but the scan timeline keeps running.
        bus_write(16'h6007, 8'h00);
        base = t0 + 128 * ((cyc - t0) / 128 + 1);
        for (int k = 0; k < 8; k++) begin
            wait_cyc(base + 16 * k + 3 + k);
            check_scan("disabled", 8'h00, 1'b0);
        end
        bus_write(16'h6007, 8'h01);
        base = t0 + 128 * ((cyc - t0) / 128 + 1);
        for (int k = 0; k < 8; k++) begin
            wait_cyc(base + 16 * k + 9);
            check_scan("reenabled", 8'h00, 1'b1);
        end

        // Address decode: outside-window writes and reads.
        bus_write(16'h6008, 8'h55);
        bus_write(16'h5FFF, 8'hAA);
        for (int i = 0; i < 8; i++) begin
            bus_read(16'h6000 + 16'(i), 1'b1, rd_vals[i], $sformatf("decode_rd%0d", i));
        end
        bus_read(16'h6008, 1'b0, 8'h00, "miss_6008");
        bus_read(16'h5FFF, 1'b0, 8'h00, "miss_5fff");

        // LED register: one clk of output latency, upper bits discarded.
        bus_write(16'h6006, 8'hFF);
        check8("led.latency", {4'h0, led}, 8'h00);
        @(negedge clk);
        check8("led.update", {4'h0, led}, 8'h0F);
        bus_read(16'h6006, 1'b1, 8'h0F, "led_rd");
        bus_write(16'h6006, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        check8("led.nostrobe", {4'h0, led}, 8'h0F);
        bus_read(16'h6006, 1'b1, 8'h0F, "led_rd_nostrobe");

        repeat (3) @(negedge clk);
        n_vec++;
        if (rd_q.size() != 0) begin
            n_bad++;
            $display("FAIL rd_pending: got %0d unread expectations expected 0", rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
